fifo_tx_arbiter: RTL and testbench

Round-robin read scheduler that shares one UART transmitter between `NumCh` transmit FIFOs. It watches each FIFO controller's empty flag and pops one byte at a time from the granted channel. Each byte is presented to the transmitter through a valid/ready handshake. A channel keeps the grant for up to `BurstMax` bytes before the grant rotates. The block sits between the per-channel FIFO controller/buffer pairs and the single TX serializer.

---
 rtl/fifo_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_arbiter.sv
// Round-robin scheduler that pops bytes from NumCh transmit FIFOs and feeds
// them one at a time to a single UART transmitter over a valid/ready handshake.
module fifo_tx_arbiter #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned BurstMax  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NumCh-1:0]           i_empty,
  input  logic [NumCh-1:0]           i_ch_en,
  input  logic [NumCh*DataWidth-1:0] i_rd_data,
  output logic [NumCh-1:0]           o_rd_en,
  output logic [DataWidth-1:0]       o_tx_data,
  output logic                       o_tx_valid,
  output logic [$clog2(NumCh)-1:0]   o_tx_ch,
  input  logic                       i_tx_ready,
  output logic                       o_busy
);

  localparam int unsigned ChWidth  = $clog2(NumCh);
  localparam int unsigned CntWidth = $clog2(BurstMax + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]           r_state,      w_state_nxt;
  logic [ChWidth-1:0]   r_grant,      w_grant_nxt;
  logic [ChWidth-1:0]   r_last_grant, w_last_nxt;
  logic [CntWidth-1:0]  r_burst_cnt,  w_burst_nxt;
  logic [NumCh-1:0]     r_rd_en,      w_rd_en_nxt;
  logic [DataWidth-1:0] r_tx_data,    w_tx_data_nxt;
  logic                 r_tx_valid,   w_tx_valid_nxt;
  logic [ChWidth-1:0]   r_tx_ch,      w_tx_ch_nxt;
  logic                 r_busy,       w_busy_nxt;

  logic [NumCh-1:0]     w_elig;
  logic                 w_found;
  logic [ChWidth-1:0]   w_sel;
  logic [ChWidth-1:0]   w_cand;
  int unsigned          w_idx;
  logic [DataWidth-1:0] w_rd_sel;
  logic                 w_more;

  assign w_elig = ~i_empty & i_ch_en;

  // First eligible channel searching upward from the one after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NumCh; k++) begin
      w_idx  = (32'(r_last_grant) + k) % NumCh;
      w_cand = ChWidth'(w_idx);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_rd_sel = '0;
    for (int unsigned n = 0; n < NumCh; n++) begin
      if (r_grant == ChWidth'(n)) begin
        w_rd_sel = i_rd_data[n*DataWidth +: DataWidth];
      end
    end
  end

  // Keep the grant only while the burst budget remains and the channel stays eligible.
  assign w_more = (r_burst_cnt < CntWidth'(BurstMax)) && w_elig[r_grant];

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last_grant;
    w_burst_nxt    = r_burst_cnt;
    w_rd_en_nxt    = '0;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_ch_nxt    = r_tx_ch;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel;
          w_burst_nxt = '0;
          w_rd_en_nxt = NumCh'(1) << w_sel;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_tx_data_nxt  = w_rd_sel;
        w_tx_ch_nxt    = r_grant;
        w_tx_valid_nxt = 1'b1;
        w_burst_nxt    = r_burst_cnt + CntWidth'(1);
        w_state_nxt    = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          if (w_more) begin
            w_rd_en_nxt = NumCh'(1) << r_grant;
            w_state_nxt = LOAD;
          end else begin
            w_last_nxt  = r_grant;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= ChWidth'(NumCh - 1);
      r_burst_cnt  <= '0;
      r_rd_en      <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_ch      <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_tx_ch      <= w_tx_ch_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign o_rd_en    = r_rd_en;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_ch    = r_tx_ch;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Bench for fifo_tx_arbiter: FIFO environment, cycle model of the scheduling
// rules, per-cycle output compare, directed scenarios and a random soak.
module tb_fifo_tx_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int BM  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] rd_data;
  logic [NCH-1:0]    rd_en;
  logic [DW-1:0]     tx_data;
  logic              tx_valid;
  logic [1:0]        tx_ch;
  logic              tx_ready;
  logic              busy;

  always #5 clk = ~clk;

  fifo_tx_arbiter #(.NumCh(NCH), .DataWidth(DW), .BurstMax(BM)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_empty    (empty),
    .i_ch_en    (ch_en),
    .i_rd_data  (rd_data),
    .o_rd_en    (rd_en),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_tx_ch    (tx_ch),
    .i_tx_ready (tx_ready),
    .o_busy     (busy)
  );

  // FIFO environment: circular buffers, popped on the DUT's strobe.
  logic [DW-1:0] mem [NCH][256];
  int head [NCH] = '{default: 0};
  int tail [NCH] = '{default: 0};
  int pops = 0;

  int checks = 0;
  int errors = 0;

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      empty[n]            = (head[n] == tail[n]);
      rd_data[n*DW +: DW] = mem[n][head[n] & 255];
    end
  end

  // Expected outputs and scheduling bookkeeping.
  logic [NCH-1:0] m_rd_en = '0;
  logic           m_valid = 1'b0;
  logic           m_busy  = 1'b0;
  logic [DW-1:0]  m_data  = '0;
  logic [1:0]     m_ch    = '0;
  logic [1:0]     m_grant = '0;
  logic [1:0]     m_last  = 2'(NCH - 1);
  int             m_sent  = 0;
  bit             m_known = 1'b0;
  int             log_q [$];
  int             exp_q [$];

  function automatic bit elig(input int c);
    return (head[c] != tail[c]) && ch_en[c];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  c;
    bit  found;
    if (rst) begin
      m_rd_en = '0; m_valid = 1'b0; m_busy = 1'b0; m_data = '0; m_ch = '0;
      m_grant = '0; m_last = 2'(NCH - 1); m_sent = 0; m_known = 1'b1;
    end else if (m_rd_en != '0) begin
      m_data  = mem[m_grant][head[m_grant] & 255];
      m_ch    = m_grant;
      m_valid = 1'b1;
      m_sent++;
      m_rd_en = '0;
    end else if (m_valid) begin
      if (tx_ready) begin
        log_q.push_back(int'(m_ch) * 256 + int'(m_data));
        m_valid = 1'b0;
        if (m_sent < BM && elig(int'(m_grant))) begin
          m_rd_en = 4'b0001 << m_grant;
        end else begin
          m_last = m_grant;
          m_busy = 1'b0;
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        c = (int'(m_last) + k) % NCH;
        if (!found && elig(c)) begin
          found   = 1'b1;
          m_grant = 2'(c);
          m_sent  = 0;
          m_rd_en = 4'b0001 << m_grant;
          m_busy  = 1'b1;
        end
      end
    end
    for (int n = 0; n < NCH; n++) begin
      if (rd_en[n] && head[n] != tail[n]) begin
        head[n] <= head[n] + 1;
        pops++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("rd_en",    int'(rd_en),    int'(m_rd_en));
      chk("tx_valid", int'(tx_valid), int'(m_valid));
      chk("tx_data",  int'(tx_data),  int'(m_data));
      chk("tx_ch",    int'(tx_ch),    int'(m_ch));
      chk("busy",     int'(busy),     int'(m_busy));
      chk("rd_en_onehot", ($countones(rd_en) <= 1) ? 1 : 0, 1);
      for (int n = 0; n < NCH; n++) begin
        if (rd_en[n]) chk("pop_nonempty", int'(empty[n]), 0);
      end
    end
  end

  task automatic push(input int c, input logic [DW-1:0] d);
    mem[c][tail[c] & 255] = d;
    tail[c] = tail[c] + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int n = 0; n < NCH; n++) tail[n] = head[n];
    log_q.delete();
    ch_en    = 4'hF;
    tx_ready = 1'b1;
    rst      = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (log_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (log_q.size() < n) chk("log_timeout", log_q.size(), n);
  endtask

  task automatic wait_valid(input int budget);
    int cyc;
    cyc = 0;
    while (!tx_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!tx_valid) chk("valid_timeout", int'(tx_valid), 1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk(name, log_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int p0;
    int cyc;
    bit done;
    rst = 1'b1; ch_en = 4'hF; tx_ready = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_busy",  int'(busy),     0);
    chk("reset_valid", int'(tx_valid), 0);
    chk("reset_rd_en", int'(rd_en),    0);
    chk("reset_data",  int'(tx_data),  0);

    // Single byte on channel 2.
    push(2, 8'hA5);
    @(negedge clk);
    chk("single_rd_en", int'(rd_en), 4'b0100);
    @(negedge clk);
    chk("single_valid", int'(tx_valid), 1);
    chk("single_data",  int'(tx_data),  8'hA5);
    chk("single_ch",    int'(tx_ch),    2);
    @(negedge clk);
    chk("single_idle",  int'(busy),     0);
    chk("single_done",  int'(tx_valid), 0);

    // Round robin with wrap back to channel 0.
    do_reset();
    for (int n = 0; n < NCH; n++) push(n, 8'(8'h10 + n));
    wait_log(4, 100);
    push(0, 8'hAA);
    wait_log(5, 100);
    exp_q = '{'h010, 'h111, 'h212, 'h313, 'h0AA};
    check_log("rr_order");

    // Burst limit.
    do_reset();
    p0 = pops;
    for (int i = 0; i < 6; i++) push(1, 8'(8'h20 + i));
    push(3, 8'h30);
    wait_log(7, 200);
    repeat (5) @(negedge clk);
    exp_q = '{'h120, 'h121, 'h122, 'h123, 'h330, 'h124, 'h125};
    check_log("burst_order");
    chk("burst_pops", pops - p0, 7);

    // Backpressure for five cycles.
    do_reset();
    tx_ready = 1'b0;
    push(0, 8'h55);
    wait_valid(10);
    repeat (5) begin
      chk("bp_valid", int'(tx_valid), 1);
      chk("bp_data",  int'(tx_data),  8'h55);
      chk("bp_ch",    int'(tx_ch),    0);
      chk("bp_rd_en", int'(rd_en),    0);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", int'(tx_valid), 0);
    exp_q = '{'h055};
    check_log("bp_log");

    // Channel 1 masked off.
    do_reset();
    ch_en = 4'b1101;
    for (int n = 0; n < NCH; n++) begin
      push(n, 8'(8'h80 + 2 * n));
      push(n, 8'(8'h81 + 2 * n));
    end
    wait_log(6, 200);
    repeat (10) @(negedge clk);
    exp_q = '{'h080, 'h081, 'h284, 'h285, 'h386, 'h387};
    check_log("mask_order");
    chk("mask_ch1_depth", tail[1] - head[1], 2);

    // Enable dropped while channel 0 is mid-burst.
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 8'(8'h40 + i));
    push(2, 8'h50);
    wait_valid(10);
    ch_en[0] = 1'b0;
    wait_log(2, 50);
    repeat (8) @(negedge clk);
    chk("mid_en_parked", log_q.size(), 2);
    ch_en = 4'hF;
    wait_log(5, 100);
    exp_q = '{'h040, 'h250, 'h041, 'h042, 'h043};
    check_log("mid_en_order");

    // Reset while a byte is waiting for the transmitter.
    do_reset();
    tx_ready = 1'b0;
    push(2, 8'h77);
    wait_valid(10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_busy",  int'(busy),     0);
    chk("rst_rd_en", int'(rd_en),    0);
    push(0, 8'h66);
    push(2, 8'h78);
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_log(2, 50);
    exp_q = '{'h066, 'h278};
    check_log("rst_order");

    // Random soak against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int c;
      c = int'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 2) == 0 && (tail[c] - head[c]) < 200) push(c, 8'($urandom));
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) ch_en = 4'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; ch_en = 4'hF; tx_ready = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      done = (empty == 4'hF) && !busy;
    end
    chk("drain", int'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
